// File: rtl/adc_emu_pkg.sv
// Shared constants, state type and frame-word helper for the ADC128S022 responder.
package adc_emu_pkg;

  localparam int ADC_BITS       = 12;
  localparam int FRAME_BITS     = 16;
  localparam int NUM_CH         = 8;
  localparam int ADDR_FIRST_BIT = 3;
  localparam int ADDR_LAST_BIT  = 5;
  localparam int CNT_W          = 5;
  localparam int ADDR_W         = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Frame word for one channel: leading zeros, then the 12-bit sample.
  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [ADC_BITS*NUM_CH-1:0] data,
    input logic [ADDR_W-1:0]          ch
  );
    logic [ADC_BITS-1:0] sample;
    sample = data[ch*ADC_BITS +: ADC_BITS];
    return {{(FRAME_BITS-ADC_BITS){1'b0}}, sample};
  endfunction

endpackage

// File: rtl/adc128s022_responder_sync_edge_det.sv
// N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one extra flop holding the previous synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_in};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/adc128s022_responder.sv
// ADC128S022 serial-interface responder: decodes the channel address from DIN
// and shifts the selected 12-bit sample out on DOUT, one frame per 16 SCK periods.
module adc128s022_responder
  import adc_emu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_50M,
  input  logic                       rst_n,
  input  logic                       adc_sck,
  input  logic                       adc_cs_n,
  input  logic                       adc_din,
  input  logic [ADC_BITS*NUM_CH-1:0] ch_data,
  output logic                       adc_dout,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [ADDR_W-1:0]          last_addr
);

  logic                   sck_rise_s;
  logic                   sck_fall_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;
  logic [SYNC_STAGES-1:0] din_dly_r;
  logic                   din_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic [ADDR_W-1:0]      cur_addr_r;
  logic [ADDR_W-1:0]      addr_cap_r;
  logic [FRAME_BITS-1:0]  shift_r;
  logic [FRAME_BITS-1:0]  shift_next_s;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck_sync (
    .clk      (clk_50M),
    .rst_n    (rst_n),
    .async_in (adc_sck),
    .rise     (sck_rise_s),
    .fall     (sck_fall_s)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk      (clk_50M),
    .rst_n    (rst_n),
    .async_in (adc_cs_n),
    .rise     (cs_rise_s),
    .fall     (cs_fall_s)
  );

  // DIN delay line matched to the SCK synchronizer so captured bits line up with SCK edges.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      din_dly_r <= {SYNC_STAGES{1'b0}};
    end else begin
      din_dly_r <= {din_dly_r[SYNC_STAGES-2:0], adc_din};
    end
  end

  assign din_s = din_dly_r[SYNC_STAGES-1];

  // Next bit count and next shift-register contents; the first falling edge of a frame loads the sample.
  always_comb begin
    cnt_next_s   = bit_cnt_r + 5'd1;
    shift_next_s = {FRAME_BITS{1'b0}};
    if (bit_cnt_r == 5'd0) begin
      shift_next_s = frame_word(ch_data, cur_addr_r);
    end else begin
      shift_next_s = {shift_r[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Frame FSM: CS edges take priority over SCK edges seen in the same cycle.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 5'd0;
      cur_addr_r <= 3'd0;
      addr_cap_r <= 3'd0;
      shift_r    <= 16'h0000;
      adc_dout   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      last_addr  <= 3'd0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (cs_fall_s) begin
        state_r    <= ACTIVE;
        bit_cnt_r  <= 5'd0;
        cur_addr_r <= 3'd0;
        shift_r    <= 16'h0000;
        adc_dout   <= 1'b0;
      end else if (cs_rise_s) begin
        state_r    <= IDLE;
        frame_err  <= (bit_cnt_r != 5'd0);
        bit_cnt_r  <= 5'd0;
        addr_cap_r <= 3'd0;
        shift_r    <= 16'h0000;
        adc_dout   <= 1'b0;
      end else if (state_r == ACTIVE) begin
        if (sck_fall_s) begin
          shift_r  <= shift_next_s;
          adc_dout <= shift_next_s[FRAME_BITS-1];
        end else if (sck_rise_s) begin
          if (cnt_next_s == 5'(FRAME_BITS)) begin
            bit_cnt_r  <= 5'd0;
            cur_addr_r <= addr_cap_r;
            last_addr  <= addr_cap_r;
            frame_done <= 1'b1;
          end else begin
            bit_cnt_r <= cnt_next_s;
            case (cnt_next_s)
              5'(ADDR_FIRST_BIT):     addr_cap_r[2] <= din_s;
              5'(ADDR_FIRST_BIT + 1): addr_cap_r[1] <= din_s;
              5'(ADDR_LAST_BIT):      addr_cap_r[0] <= din_s;
              default:                addr_cap_r    <= addr_cap_r;
            endcase
          end
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end else begin
        bit_cnt_r <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Self-checking bench: drives the SPI-like controller side and compares against a channel-array model.
module tb_adc128s022_responder;

  localparam int SYNC = 2;

  logic        clk_50M;
  logic        rst_n;
  logic        adc_sck;
  logic        adc_cs_n;
  logic        adc_din;
  logic [95:0] ch_data;
  logic        adc_dout;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  last_addr;

  adc128s022_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .adc_sck    (adc_sck),
    .adc_cs_n   (adc_cs_n),
    .adc_din    (adc_din),
    .ch_data    (ch_data),
    .adc_dout   (adc_dout),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .last_addr  (last_addr)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          half     = 8;
  logic [11:0] ch_arr [8];
  logic [2:0]  m_next;
  logic [2:0]  m_last;

  always @(negedge clk_50M) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_ch();
    for (int n = 0; n < 8; n++) ch_data[n*12 +: 12] = ch_arr[n];
  endtask

  task automatic cs_low();
    @(negedge clk_50M);
    adc_cs_n = 1'b0;
    m_next   = 3'd0;
    repeat (4) @(negedge clk_50M);
  endtask

  task automatic cs_high();
    @(negedge clk_50M);
    adc_cs_n = 1'b1;
    repeat (8) @(negedge clk_50M);
  endtask

  // One controller frame of nrise SCK periods; optionally rewrites ch0 after rising edge chg_at.
  task automatic run_frame(input logic [2:0] addr, input int nrise, input int chg_at,
                           input logic [11:0] chg_val, output logic [15:0] word, output int done_lat);
    word     = 16'h0000;
    done_lat = -1;
    for (int i = 0; i < nrise; i++) begin
      adc_sck = 1'b0;
      if (i == 2)      adc_din = addr[2];
      else if (i == 3) adc_din = addr[1];
      else if (i == 4) adc_din = addr[0];
      else             adc_din = 1'($urandom_range(0, 1));
      repeat (half) @(negedge clk_50M);
      word    = {word[14:0], adc_dout};
      adc_sck = 1'b1;
      if (i + 1 == chg_at) begin
        ch_arr[0] = chg_val;
        apply_ch();
      end
      for (int j = 1; j <= half; j++) begin
        @(negedge clk_50M);
        if (frame_done === 1'b1 && done_lat < 0) done_lat = j;
      end
    end
  endtask

  logic [15:0] w;
  int          lat;
  int          d0;
  int          e0;
  logic [2:0]  a;
  int          nfr;

  initial begin
    rst_n    = 1'b0;
    adc_sck  = 1'b1;
    adc_cs_n = 1'b1;
    adc_din  = 1'b0;
    for (int n = 0; n < 8; n++) ch_arr[n] = 12'($urandom);
    apply_ch();
    m_next = 3'd0;
    m_last = 3'd0;
    repeat (3) @(negedge clk_50M);
    chk("rst dout", 32'(adc_dout), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst last_addr", 32'(last_addr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50M);

    // Two frames: address 5 then ch5 comes back in the second frame.
    ch_arr[0] = 12'hABC;
    ch_arr[5] = 12'h123;
    apply_ch();
    d0 = done_cnt;
    e0 = err_cnt;
    cs_low();
    run_frame(3'd5, 16, 0, 12'h000, w, lat);
    chk("A1 word", 32'(w), 32'h0ABC);
    chk("A1 last_addr", 32'(last_addr), 32'd5);
    chk("A1 done count", 32'(done_cnt - d0), 32'd1);
    chk("A1 done latency", 32'(lat), 32'(SYNC + 1));
    a = 3'($urandom_range(0, 7));
    run_frame(a, 16, 0, 12'h000, w, lat);
    chk("A2 word", 32'(w), 32'h0123);
    chk("A2 last_addr", 32'(last_addr), 32'(a));
    cs_high();
    chk("A done total", 32'(done_cnt - d0), 32'd2);
    chk("A no err", 32'(err_cnt - e0), 32'd0);

    // Back-to-back frames with CS held low.
    ch_arr[2] = 12'hFFF;
    ch_arr[7] = 12'h001;
    apply_ch();
    d0 = done_cnt;
    cs_low();
    run_frame(3'd2, 16, 0, 12'h000, w, lat);
    chk("B1 word", 32'(w), 32'({4'h0, ch_arr[0]}));
    run_frame(3'd7, 16, 0, 12'h000, w, lat);
    chk("B2 word", 32'(w), 32'h0FFF);
    run_frame(3'd0, 16, 0, 12'h000, w, lat);
    chk("B3 word", 32'(w), 32'h0001);
    chk("B3 done latency", 32'(lat), 32'(SYNC + 1));
    cs_high();
    chk("B done count", 32'(done_cnt - d0), 32'd3);
    chk("B last_addr", 32'(last_addr), 32'd0);

    // Aborted frame after 7 rising edges.
    cs_low();
    run_frame(3'd4, 16, 0, 12'h000, w, lat);
    chk("C0 last_addr", 32'(last_addr), 32'd4);
    e0 = err_cnt;
    d0 = done_cnt;
    run_frame(3'd6, 7, 0, 12'h000, w, lat);
    cs_high();
    chk("C err count", 32'(err_cnt - e0), 32'd1);
    chk("C no done", 32'(done_cnt - d0), 32'd0);
    chk("C last_addr kept", 32'(last_addr), 32'd4);
    cs_low();
    run_frame(3'd2, 16, 0, 12'h000, w, lat);
    chk("C next word ch0", 32'(w), 32'({4'h0, ch_arr[0]}));
    cs_high();

    // Sample snapshot: ch0 changes mid-frame.
    ch_arr[0] = 12'h555;
    apply_ch();
    cs_low();
    run_frame(3'd0, 16, 8, 12'hAAA, w, lat);
    chk("D1 word snapshot", 32'(w), 32'h0555);
    run_frame(3'd0, 16, 0, 12'h000, w, lat);
    chk("D2 word updated", 32'(w), 32'h0AAA);
    cs_high();

    // SCK activity with CS high must be ignored.
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 20; i++) begin
      adc_sck = 1'b0;
      repeat (half) @(negedge clk_50M);
      chk("E dout low", 32'(adc_dout), 32'd0);
      adc_sck = 1'b1;
      repeat (half) @(negedge clk_50M);
      chk("E dout high", 32'(adc_dout), 32'd0);
    end
    chk("E no done", 32'(done_cnt - d0), 32'd0);
    chk("E no err", 32'(err_cnt - e0), 32'd0);

    // Randomized sessions at the fastest supported SCK rate.
    half = 4;
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 8; n++) ch_arr[n] = 12'($urandom);
      apply_ch();
      d0  = done_cnt;
      nfr = $urandom_range(1, 4);
      cs_low();
      for (int f = 0; f < nfr; f++) begin
        a = 3'($urandom_range(0, 7));
        run_frame(a, 16, 0, 12'h000, w, lat);
        chk("R word", 32'(w), 32'({4'h0, ch_arr[m_next]}));
        m_next = a;
        m_last = a;
        chk("R last_addr", 32'(last_addr), 32'(m_last));
      end
      cs_high();
      chk("R done count", 32'(done_cnt - d0), 32'(nfr));
    end
    half = 8;

    // Reset during bit 9 of a frame.
    cs_low();
    run_frame(3'd6, 16, 0, 12'h000, w, lat);
    chk("F0 last_addr", 32'(last_addr), 32'd6);
    run_frame(3'd3, 9, 0, 12'h000, w, lat);
    rst_n    = 1'b0;
    adc_sck  = 1'b1;
    adc_cs_n = 1'b1;
    #1;
    chk("F rst dout", 32'(adc_dout), 32'd0);
    chk("F rst frame_done", 32'(frame_done), 32'd0);
    chk("F rst frame_err", 32'(frame_err), 32'd0);
    chk("F rst last_addr", 32'(last_addr), 32'd0);
    repeat (5) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);
    d0 = done_cnt;
    e0 = err_cnt;
    cs_low();
    run_frame(3'd1, 16, 0, 12'h000, w, lat);
    chk("F post-reset word", 32'(w), 32'({4'h0, ch_arr[0]}));
    chk("F post-reset last_addr", 32'(last_addr), 32'd1);
    cs_high();
    chk("F done count", 32'(done_cnt - d0), 32'd1);
    chk("F no err", 32'(err_cnt - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc128s022_responder.md
# adc128s022_responder

Synthesizable responder for the ADC128S022 serial interface, the other end of the ADC controller that drives `adc_cs_n`, `adc_sck` and `adc_din`. It decodes the 3-bit channel address from DIN and returns the selected channel's 12-bit sample on DOUT. Sample values come from a parallel input. It replaces the physical ADC in hardware-in-the-loop and bench runs of the line-following path, with no change to the controller.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `adc_sck` and `adc_cs_n`; minimum 2.
- `clk_50M`  in  1  system clock; `adc_sck` is oversampled in this domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `adc_sck`  in  1  serial clock from the controller; idles high.
- `adc_cs_n`  in  1  chip select, active low.
- `adc_din`  in  1  address/control bits from the controller.
- `ch_data`  in  96  eight 12-bit samples; channel n is `ch_data[12n+11:12n]`.
- `adc_dout`  out  1  serial sample data, MSB first.
- `frame_done`  out  1  one-cycle pulse after the 16th SCK rising edge of a frame.
- `frame_err`  out  1  one-cycle pulse when CS rises with a partial frame.
- `last_addr`  out  3  address decoded in the last completed frame.

## Operation
- Input handling: `adc_sck` and `adc_cs_n` pass through `SYNC_STAGES` flops, then edge detection. `adc_din` is delayed by the same number of stages so it stays aligned with SCK. All logic acts on the synchronized edges.
- States:
  - IDLE: `cs_n` high. `bit_cnt`=0, `adc_dout`=0, SCK edges ignored.
  - ACTIVE: `cs_n` low.
- IDLE→ACTIVE on the `cs_n` falling edge:
  - `cur_addr`←0, because the first conversion after CS falls is IN0.
  - `bit_cnt`←0.
  - `adc_dout`=0.
- SCK falling edge in ACTIVE:
  - If `bit_cnt`==0: load the 16-bit shift register with {4'b0, `ch_data[cur_addr]`}. This snapshot is the only point where `ch_data` is sampled.
  - Otherwise: shift left by one, zero-filled.
  - `adc_dout` is always the shift register MSB.
- SCK rising edge in ACTIVE:
  - `bit_cnt`++.
  - On counts 3, 4 and 5, capture DIN into `addr_cap[2]`, `addr_cap[1]` and `addr_cap[0]` respectively. All other DIN bits are don't-care.
- On rising edge 16:
  - `bit_cnt`←0.
  - `cur_addr`←`addr_cap`.
  - `last_addr`←`addr_cap`.
  - `frame_done` pulses.
  - With CS still low, the next frame starts immediately (back-to-back frames).
- ACTIVE→IDLE on the `cs_n` rising edge:
  - If `bit_cnt`≠0: pulse `frame_err` and discard `addr_cap`; `last_addr` is unchanged.
  - `adc_dout`←0 and the shift register is cleared.
- Simultaneous events: if a `cs_n` edge and an SCK edge are detected in the same cycle, the CS edge wins and the SCK edge is dropped.
- Reset values:
  - `adc_dout`=0, `frame_done`=0, `frame_err`=0, `last_addr`=0.
  - State IDLE, `cur_addr`=0, `bit_cnt`=0.
  - Synchronizer flops reset to idle levels: `cs_n`=1, `sck`=1.
- Reset mid-frame: all outputs return to reset values immediately. A new frame starts only on the next `cs_n` falling edge observed after reset release.

## Timing
- Pin-to-effect latency is `SYNC_STAGES`+1 `clk_50M` cycles:
  - `adc_dout` updates that many cycles after an `adc_sck` falling edge at the pin.
  - `frame_done` asserts that many cycles after the 16th rising edge at the pin.
  - `frame_err` asserts that many cycles after a CS rise at the pin.
- Supported SCK rate: up to `clk_50M`/8 (minimum half period 4 cycles).
  - At 3.125 MHz the half period is 8 cycles, so DOUT is stable at least 5 cycles before the controller samples on the rising edge.
- Output registers: `adc_dout`, `frame_done`, `frame_err` and `last_addr` are driven directly from flops, with no combinational path from inputs.
- Bit period: each bit lasts exactly one SCK period. The frame word is 4 leading zeros followed by D11..D0.

## Structure
- Package `adc_emu_pkg` holds:
  - `ADC_BITS`=12, `FRAME_BITS`=16, `NUM_CH`=8.
  - `ADDR_FIRST_BIT`=3, `ADDR_LAST_BIT`=5.
  - The state enum {IDLE, ACTIVE}.
- Sub-module `sync_edge_det` (N-stage synchronizer with rise/fall pulse outputs) is instantiated once for `adc_sck` and once for `adc_cs_n`.
- The top level holds the FSM, counter, shift register and address capture.

## Test plan
- Two consecutive frames with `ch_data` ch0=0xABC and ch5=0x123:
  - Frame 1 has DIN address 5 and returns 0x0ABC, with `last_addr`=5 and one `frame_done` pulse.
  - Frame 2 returns 0x0123.
- CS held low for three back-to-back frames with addresses 2, 7, 0 and ch2=0xFFF, ch7=0x001:
  - DOUT words are ch0, then 0x0FFF, then 0x0001.
  - `frame_done` pulses 3 times.
- CS raised after 7 rising edges:
  - `frame_err` pulses once and `last_addr` is unchanged.
  - The next frame returns ch0 regardless of the aborted address.
- `ch_data[ch0]` changed from 0x555 to 0xAAA at rising edge 8 of a frame: the current word stays 0x0555 and the next frame reading ch0 returns 0x0AAA.
- 20 SCK cycles toggled with CS high: `adc_dout`=0 throughout, with no `frame_done` or `frame_err` pulse.
- `rst_n` asserted at bit 9: all outputs go to 0 within the same cycle; after release, a full frame returns ch0 correctly.
